// File: rtl/gavgunpool_if.sv
// Handshake bundle for the global average unpooling stage.
// The input sample side and the output beat side each use a valid/ready pair.
interface gavgunpool_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic                  gavgunpool_ready_in;
  logic                  gavgunpool_valid_in;
  logic [DATA_WIDTH-1:0] gavgunpool_data_in;
  logic                  gavgunpool_ready_out;
  logic                  gavgunpool_valid_out;
  logic [DATA_WIDTH-1:0] gavgunpool_data_out;
  logic                  gavgunpool_last_out;

  modport slave (
    output gavgunpool_ready_in,
    input  gavgunpool_valid_in,
    input  gavgunpool_data_in,
    input  gavgunpool_ready_out,
    output gavgunpool_valid_out,
    output gavgunpool_data_out,
    output gavgunpool_last_out
  );

  modport master (
    input  gavgunpool_ready_in,
    output gavgunpool_valid_in,
    output gavgunpool_data_in,
    output gavgunpool_ready_out,
    input  gavgunpool_valid_out,
    input  gavgunpool_data_out,
    input  gavgunpool_last_out
  );
endinterface

// File: rtl/gavgunpool.sv
// Global average unpooling: replays each accepted sample as POOL_SIZE beats,
// optionally scaled by 1/2^clog2(POOL_SIZE) once at load time.
module gavgunpool #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned POOL_SIZE  = 256,
  parameter bit          SCALE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  gavgunpool_if.slave unpool_io
);
  localparam int unsigned SHIFT         = $clog2(POOL_SIZE);
  localparam int unsigned COUNTER_WIDTH = (SHIFT > 1) ? SHIFT : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]    data_q,  data_d;
  logic                     valid_q, valid_d;
  logic                     last_q,  last_d;

  logic                  ready_in;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  next_is_last;
  logic [DATA_WIDTH-1:0] scaled;

  // Reload is allowed on the cycle the final beat leaves, giving gapless bursts.
  assign ready_in = (state_q == ST_IDLE) |
                    ((state_q == ST_EMIT) & last_q & unpool_io.gavgunpool_ready_out);
  assign in_xfer  = unpool_io.gavgunpool_valid_in & ready_in;
  assign out_xfer = valid_q & unpool_io.gavgunpool_ready_out;

  assign next_is_last = ((32'(count_q) + 32'd1) == 32'(POOL_SIZE - 1));

  assign scaled = SCALE_EN ? DATA_WIDTH'($signed(unpool_io.gavgunpool_data_in) >>> SHIFT)
                           : unpool_io.gavgunpool_data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (in_xfer) begin
          data_d  = scaled;
          count_d = '0;
          last_d  = (POOL_SIZE == 1);
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_xfer) begin
          if (!last_q) begin
            count_d = count_q + 1'b1;
            last_d  = next_is_last;
          end else if (in_xfer) begin
            data_d  = scaled;
            count_d = '0;
            last_d  = (POOL_SIZE == 1);
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  assign unpool_io.gavgunpool_ready_in  = ready_in;
  assign unpool_io.gavgunpool_valid_out = valid_q;
  assign unpool_io.gavgunpool_data_out  = data_q;
  assign unpool_io.gavgunpool_last_out  = last_q;
endmodule

// File: tb/tb_gavgunpool.sv
// Bench for gavgunpool: a POOL_SIZE=4 scaled instance and a POOL_SIZE=1 pass-through
// instance, both checked against a queue of expected beats built from the sample values.
module tb_gavgunpool;
  localparam int unsigned DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gavgunpool_if #(.DATA_WIDTH(DW)) a_if ();
  gavgunpool_if #(.DATA_WIDTH(DW)) b_if ();

  gavgunpool #(.DATA_WIDTH(DW), .POOL_SIZE(4), .SCALE_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .unpool_io(a_if.slave));
  gavgunpool #(.DATA_WIDTH(DW), .POOL_SIZE(1), .SCALE_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .unpool_io(b_if.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Expected beats still owed, each entry {last, data}; feeds are samples waiting to be sent.
  logic [DW:0]   qa[$];
  logic [DW:0]   qb[$];
  logic [DW-1:0] fa[$];
  logic [DW-1:0] fb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Average broadcast: floor(x / 2^k) of the signed sample.
  function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] x, input int k);
    int v;
    int d;
    int r;
    v = int'($signed(x));
    d = 1 << k;
    if (v >= 0) r = v / d;
    else        r = -((-v + d - 1) / d);
    return DW'(r);
  endfunction

  task automatic step(input bit rand_a, input bit rand_b);
    logic ra, rb, xa_in, xb_in;
    @(negedge clk);
    a_if.gavgunpool_valid_in  = (fa.size() != 0);
    a_if.gavgunpool_data_in   = (fa.size() != 0) ? fa[0] : DW'($urandom);
    a_if.gavgunpool_ready_out = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
    b_if.gavgunpool_valid_in  = (fb.size() != 0);
    b_if.gavgunpool_data_in   = (fb.size() != 0) ? fb[0] : DW'($urandom);
    b_if.gavgunpool_ready_out = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    ra = a_if.gavgunpool_ready_out;
    rb = b_if.gavgunpool_ready_out;

    chk("a_valid", 32'(a_if.gavgunpool_valid_out), 32'(qa.size() != 0));
    if (qa.size() != 0) begin
      chk("a_data", 32'(a_if.gavgunpool_data_out), 32'(qa[0][DW-1:0]));
      chk("a_last", 32'(a_if.gavgunpool_last_out), 32'(qa[0][DW]));
    end
    chk("a_ready_in", 32'(a_if.gavgunpool_ready_in),
        32'((qa.size() == 0) || (qa.size() == 1 && ra)));

    chk("b_valid", 32'(b_if.gavgunpool_valid_out), 32'(qb.size() != 0));
    if (qb.size() != 0) begin
      chk("b_data", 32'(b_if.gavgunpool_data_out), 32'(qb[0][DW-1:0]));
      chk("b_last", 32'(b_if.gavgunpool_last_out), 32'(qb[0][DW]));
    end
    chk("b_ready_in", 32'(b_if.gavgunpool_ready_in),
        32'((qb.size() == 0) || (qb.size() == 1 && rb)));

    xa_in = a_if.gavgunpool_valid_in & a_if.gavgunpool_ready_in;
    xb_in = b_if.gavgunpool_valid_in & b_if.gavgunpool_ready_in;
    if (a_if.gavgunpool_valid_out && ra && qa.size() != 0) void'(qa.pop_front());
    if (b_if.gavgunpool_valid_out && rb && qb.size() != 0) void'(qb.pop_front());
    if (xa_in) begin
      for (int i = 0; i < 4; i++)
        qa.push_back({1'(i == 3), ref_scale(fa[0], 2)});
      void'(fa.pop_front());
    end
    if (xb_in) begin
      qb.push_back({1'b1, fb[0]});
      void'(fb.pop_front());
    end
  endtask

  task automatic drain(input bit rnd);
    int cyc;
    cyc = 0;
    do begin
      step(rnd, rnd);
      cyc++;
    end while ((fa.size() != 0 || qa.size() != 0 || fb.size() != 0 || qb.size() != 0) && cyc < 3000);
    if (cyc >= 3000) chk("drain_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_a_valid"}, 32'(a_if.gavgunpool_valid_out), 32'd0);
    chk({tag, "_a_data"},  32'(a_if.gavgunpool_data_out),  32'd0);
    chk({tag, "_a_last"},  32'(a_if.gavgunpool_last_out),  32'd0);
    chk({tag, "_b_valid"}, 32'(b_if.gavgunpool_valid_out), 32'd0);
  endtask

  initial begin
    int cyc;
    a_if.gavgunpool_valid_in  = 1'b0;
    a_if.gavgunpool_data_in   = '0;
    a_if.gavgunpool_ready_out = 1'b1;
    b_if.gavgunpool_valid_in  = 1'b0;
    b_if.gavgunpool_data_in   = '0;
    b_if.gavgunpool_ready_out = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    chk("reset_a_ready_in", 32'(a_if.gavgunpool_ready_in), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single positive sample, then negative/rounding cases.
    fa.push_back(12'h100);
    drain(1'b0);
    fa.push_back(12'h800);
    fa.push_back(12'hFFF);
    fa.push_back(12'h003);
    drain(1'b0);

    // Back-to-back bursts with valid_in held high.
    fa.push_back(12'h100);
    fa.push_back(12'h200);
    fb.push_back(12'h123);
    fb.push_back(12'h456);
    fb.push_back(12'h789);
    drain(1'b0);

    // Random samples under random back-pressure on both instances.
    for (int i = 0; i < 25; i++) begin
      fa.push_back(DW'($urandom));
      fb.push_back(DW'($urandom));
    end
    drain(1'b1);

    // Asynchronous reset after the second beat of a burst.
    fa.push_back(12'h155);
    cyc = 0;
    while (qa.size() != 2 && cyc < 100) begin
      step(1'b0, 1'b0);
      cyc++;
    end
    chk("reset_mid_reached", 32'(qa.size()), 32'd2);
    @(negedge clk);
    a_if.gavgunpool_valid_in = 1'b0;
    b_if.gavgunpool_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    qa.delete();
    qb.delete();
    fa.delete();
    fb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready_in", 32'(a_if.gavgunpool_ready_in), 32'd1);
    fa.push_back(12'hA40);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
